// File: rtl/construtor_caminho_pkg.sv
// Shared definitions for the path builder and its controller: FSM state
// encoding and a small helper on that encoding.
package construtor_caminho_pkg;

  localparam int ESTADO_W = 3;

  localparam logic [ESTADO_W-1:0] OCIOSO = 3'd0;
  localparam logic [ESTADO_W-1:0] LER    = 3'd1;
  localparam logic [ESTADO_W-1:0] ESPERA = 3'd2;
  localparam logic [ESTADO_W-1:0] ENVIAR = 3'd3;
  localparam logic [ESTADO_W-1:0] FIM    = 3'd4;
  localparam logic [ESTADO_W-1:0] ERRO   = 3'd5;

  // Every state except OCIOSO counts as busy.
  function automatic logic estado_ocupado(input logic [ESTADO_W-1:0] e);
    return e != OCIOSO;
  endfunction

endpackage

// File: rtl/construtor_caminho_if.sv
// Bundle of controller, predecessor-memory and host signals around the
// path builder. master = path builder side, slave = its environment.
//
// Host stream handshake: a word transfers on every rising edge where
// cc_caminho_valido_out and host_lido_in are both high; while valido is high
// and lido is low, valido and addr hold stable; lido with valido low is
// ignored. The memory read returns data exactly one cycle after rd_en.
interface construtor_caminho_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int CONT_WIDTH = ADDR_WIDTH + 1
);
  logic                  cme_construir_caminho_in;
  logic [ADDR_WIDTH-1:0] top_fonte_in;
  logic [ADDR_WIDTH-1:0] top_destino_in;
  logic                  cc_anterior_rd_en_out;
  logic [ADDR_WIDTH-1:0] cc_anterior_rd_addr_out;
  logic [ADDR_WIDTH-1:0] gma_anterior_rd_data_in;
  logic                  cc_caminho_valido_out;
  logic [ADDR_WIDTH-1:0] cc_caminho_addr_out;
  logic                  host_lido_in;
  logic [CONT_WIDTH-1:0] cc_comprimento_out;
  logic                  cc_ocupado_out;
  logic                  cc_caminho_pronto_out;
  logic                  cc_erro_out;
  logic [construtor_caminho_pkg::ESTADO_W-1:0] cc_estado_dbg_out;

  modport master (
    input  cme_construir_caminho_in, top_fonte_in, top_destino_in,
           gma_anterior_rd_data_in, host_lido_in,
    output cc_anterior_rd_en_out, cc_anterior_rd_addr_out,
           cc_caminho_valido_out, cc_caminho_addr_out, cc_comprimento_out,
           cc_ocupado_out, cc_caminho_pronto_out, cc_erro_out,
           cc_estado_dbg_out
  );

  modport slave (
    output cme_construir_caminho_in, top_fonte_in, top_destino_in,
           gma_anterior_rd_data_in, host_lido_in,
    input  cc_anterior_rd_en_out, cc_anterior_rd_addr_out,
           cc_caminho_valido_out, cc_caminho_addr_out, cc_comprimento_out,
           cc_ocupado_out, cc_caminho_pronto_out, cc_erro_out,
           cc_estado_dbg_out
  );
endinterface

// File: rtl/construtor_caminho_pilha.sv
// pilha_caminho: LIFO holding the nodes of a path while it is walked
// backwards, so they can be replayed fonte first. Top is read straight
// from the storage array. PROFUNDIDADE must be a power of two.
module pilha_caminho #(
  parameter int ADDR_WIDTH   = 6,
  parameter int PROFUNDIDADE = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] din,
  output logic [ADDR_WIDTH-1:0] top,
  output logic                  vazio,
  output logic                  cheio
);
  localparam int PTR_W = $clog2(PROFUNDIDADE) + 1;

  logic [ADDR_WIDTH-1:0] mem_q [PROFUNDIDADE];
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [PTR_W-2:0]      top_idx;

  assign vazio   = (ptr_q == '0);
  assign cheio   = (ptr_q == PTR_W'(PROFUNDIDADE));
  assign top_idx = ptr_q[PTR_W-2:0] - 1'b1;
  assign top     = mem_q[top_idx];

  // Next pointer: clear wins; push and pop never arrive together.
  always_comb begin
    ptr_d = ptr_q;
    if (clear)               ptr_d = '0;
    else if (push && !cheio) ptr_d = ptr_q + 1'b1;
    else if (pop && !vazio)  ptr_d = ptr_q - 1'b1;
  end

  // Pointer register, async reset empties the stack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  // Storage array; contents need no reset since the pointer guards them.
  always_ff @(posedge clk) begin
    if (push && !cheio && !clear) mem_q[ptr_q[PTR_W-2:0]] <= din;
  end
endmodule

// File: rtl/construtor_caminho.sv
// Path builder: walks the predecessor memory from destino back to fonte,
// stacking every node, then streams the path fonte->destino to the host.
module construtor_caminho
  import construtor_caminho_pkg::*;
#(
  parameter int ADDR_WIDTH   = 6,
  parameter int PROFUNDIDADE = 2**ADDR_WIDTH,
  parameter int CONT_WIDTH   = ADDR_WIDTH + 1
) (
  input logic                  clk,
  input logic                  rst_n,
  construtor_caminho_if.master bus
);
  logic [ESTADO_W-1:0]   estado_q, estado_d;
  logic [ADDR_WIDTH-1:0] fonte_q, fonte_d;
  logic [ADDR_WIDTH-1:0] cur_q, cur_d;
  logic [CONT_WIDTH-1:0] comp_q, comp_d;
  logic [CONT_WIDTH-1:0] rest_q, rest_d;
  logic                  erro_q, erro_d;

  logic                  push_req, push, pop, clear;
  logic [ADDR_WIDTH-1:0] din, top;
  logic                  vazio, cheio;
  logic                  valido, aceite;

  assign valido = (estado_q == ENVIAR) && !vazio;
  assign aceite = valido && bus.host_lido_in;
  // The walk stops before the stack fills, so this gate never bites.
  assign push   = push_req && !cheio;

  pilha_caminho #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .PROFUNDIDADE (PROFUNDIDADE)
  ) u_pilha (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .clear (clear),
    .din   (din),
    .top   (top),
    .vazio (vazio),
    .cheio (cheio)
  );

  // Walk/stream state machine; rest counts words still to be sent.
  always_comb begin
    estado_d = estado_q;
    fonte_d  = fonte_q;
    cur_d    = cur_q;
    comp_d   = comp_q;
    rest_d   = rest_q;
    erro_d   = erro_q;
    push_req = 1'b0;
    pop      = 1'b0;
    clear    = 1'b0;
    din      = '0;
    case (estado_q)
      OCIOSO: if (bus.cme_construir_caminho_in) begin
        fonte_d  = bus.top_fonte_in;
        cur_d    = bus.top_destino_in;
        push_req = 1'b1;
        din      = bus.top_destino_in;
        comp_d   = CONT_WIDTH'(1);
        rest_d   = CONT_WIDTH'(1);
        erro_d   = 1'b0;
        estado_d = (bus.top_destino_in == bus.top_fonte_in) ? ENVIAR : LER;
      end
      LER: estado_d = ESPERA;
      ESPERA: begin
        push_req = 1'b1;
        din      = bus.gma_anterior_rd_data_in;
        comp_d   = comp_q + 1'b1;
        rest_d   = rest_q + 1'b1;
        if (bus.gma_anterior_rd_data_in == fonte_q) begin
          estado_d = ENVIAR;
        end else if (comp_q + 1'b1 == CONT_WIDTH'(PROFUNDIDADE)) begin
          estado_d = ERRO;
        end else begin
          cur_d    = bus.gma_anterior_rd_data_in;
          estado_d = LER;
        end
      end
      ENVIAR: if (aceite) begin
        pop    = 1'b1;
        rest_d = rest_q - 1'b1;
        if (rest_q == CONT_WIDTH'(1)) estado_d = FIM;
      end
      FIM: estado_d = OCIOSO;
      ERRO: begin
        erro_d   = 1'b1;
        clear    = 1'b1;
        estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  // State and datapath registers, async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= OCIOSO;
      fonte_q  <= '0;
      cur_q    <= '0;
      comp_q   <= '0;
      rest_q   <= '0;
      erro_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      fonte_q  <= fonte_d;
      cur_q    <= cur_d;
      comp_q   <= comp_d;
      rest_q   <= rest_d;
      erro_q   <= erro_d;
    end
  end

  assign bus.cc_anterior_rd_en_out   = (estado_q == LER);
  assign bus.cc_anterior_rd_addr_out = (estado_q == LER) ? cur_q : '0;
  assign bus.cc_caminho_valido_out   = valido;
  assign bus.cc_caminho_addr_out     = valido ? top : '0;
  assign bus.cc_comprimento_out      = comp_q;
  assign bus.cc_ocupado_out          = estado_ocupado(estado_q);
  assign bus.cc_caminho_pronto_out   = (estado_q == FIM);
  assign bus.cc_erro_out             = erro_q;
  assign bus.cc_estado_dbg_out       = estado_q;
endmodule

// File: tb/tb_construtor_caminho.sv
// Bench for construtor_caminho: predecessor memory responder, host lido
// driver, path model built by following the table, per-cycle compare.
module tb_construtor_caminho;
  localparam int AW = 6;
  localparam int CW = 7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  construtor_caminho_if #(.ADDR_WIDTH(AW), .CONT_WIDTH(CW)) bus();

  construtor_caminho #(.ADDR_WIDTH(AW), .PROFUNDIDADE(64), .CONT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [AW-1:0] anterior [64];
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] exp_rd_q[$];
  logic [AW-1:0] got_q[$];
  logic [AW-1:0] lit_q[$];
  int  exp_len;
  bit  exp_err;
  bit  chk_en;
  int  lido_mode;
  int  n_checks;
  int  n_err;
  int  lat;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Predecessor memory: data one cycle after rd_en.
  always @(posedge clk)
    if (bus.cc_anterior_rd_en_out)
      bus.gma_anterior_rd_data_in <= anterior[bus.cc_anterior_rd_addr_out];

  // Host lido driver: 0 always high, 1 high one cycle in three, 2 low.
  int cyc = 0;
  always @(posedge clk) begin
    #1;
    cyc++;
    case (lido_mode)
      0:       bus.host_lido_in = 1'b1;
      1:       bus.host_lido_in = (cyc % 3 == 0);
      default: bus.host_lido_in = 1'b0;
    endcase
  end

  // ---------------- model ----------------
  // Follow the table from destino until fonte; 64 nodes without reaching
  // fonte means an error and nothing streamed.
  task automatic build_model(input logic [AW-1:0] f, input logic [AW-1:0] d);
    logic [AW-1:0] nodes[$];
    logic [AW-1:0] cur, nxt;
    bit done;
    exp_q.delete();
    exp_rd_q.delete();
    exp_err = 1'b0;
    nodes.push_back(d);
    cur  = d;
    done = (d == f);
    while (!done) begin
      exp_rd_q.push_back(cur);
      nxt = anterior[cur];
      nodes.push_back(nxt);
      if (nxt == f) done = 1'b1;
      else if (nodes.size() == 64) begin exp_err = 1'b1; done = 1'b1; end
      else cur = nxt;
    end
    exp_len = nodes.size();
    if (!exp_err)
      for (int i = nodes.size() - 1; i >= 0; i--) exp_q.push_back(nodes[i]);
  endtask

  // ---------------- scoreboard / compare ----------------
  bit pronto_due;
  bit held_v;
  logic [AW-1:0] held_a;
  always @(negedge clk) begin
    if (!chk_en) begin
      pronto_due = 1'b0;
      held_v     = 1'b0;
    end else begin
      if (bus.cc_anterior_rd_en_out) begin
        if (exp_rd_q.size() == 0) chk("rd_extra", 1, 0);
        else chk("rd_addr", bus.cc_anterior_rd_addr_out, exp_rd_q.pop_front());
      end
      chk("pronto", bus.cc_caminho_pronto_out, pronto_due);
      pronto_due = 1'b0;
      if (held_v) begin
        chk("hold_valido", bus.cc_caminho_valido_out, 1);
        chk("hold_addr", bus.cc_caminho_addr_out, held_a);
      end
      held_v = 1'b0;
      if (bus.cc_caminho_valido_out) begin
        if (exp_q.size() == 0) chk("valido_extra", 1, 0);
        else begin
          chk("addr", bus.cc_caminho_addr_out, exp_q[0]);
          chk("comprimento_envio", bus.cc_comprimento_out, exp_len);
          if (bus.host_lido_in) begin
            got_q.push_back(bus.cc_caminho_addr_out);
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) pronto_due = 1'b1;
          end else begin
            held_v = 1'b1;
            held_a = bus.cc_caminho_addr_out;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_path(input logic [AW-1:0] f, input logic [AW-1:0] d, input bit keep);
    @(posedge clk); #1;
    build_model(f, d);
    got_q.delete();
    chk_en = 1'b1;
    bus.top_fonte_in   = f;
    bus.top_destino_in = d;
    bus.cme_construir_caminho_in = 1'b1;
    @(posedge clk); #1;
    bus.cme_construir_caminho_in = keep;
    // Changes after the start must have no effect.
    bus.top_fonte_in   = f ^ 6'h3F;
    bus.top_destino_in = d ^ 6'h2A;
  endtask

  task automatic finish_path(input string name, output int first_valid);
    int n;
    first_valid = -1;
    for (n = 0; n < 600; n++) begin
      @(negedge clk);
      if (bus.cc_caminho_valido_out && first_valid < 0) first_valid = n + 1;
      if (!bus.cc_ocupado_out) break;
    end
    if (n == 600) chk({name, "_timeout"}, 1, 0);
    chk({name, "_rd_left"}, exp_rd_q.size(), 0);
    chk({name, "_words_left"}, exp_q.size(), 0);
    chk({name, "_comprimento"}, bus.cc_comprimento_out, exp_len);
    chk({name, "_erro"}, bus.cc_erro_out, exp_err);
  endtask

  task automatic check_got(input string name, input logic [AW-1:0] want[$]);
    chk({name, "_count"}, got_q.size(), want.size());
    for (int i = 0; i < want.size() && i < got_q.size(); i++)
      chk({name, "_word"}, got_q[i], want[i]);
  endtask

  task automatic check_idle_outputs(input string name);
    chk({name, "_rd_en"},   bus.cc_anterior_rd_en_out, 0);
    chk({name, "_rd_addr"}, bus.cc_anterior_rd_addr_out, 0);
    chk({name, "_valido"},  bus.cc_caminho_valido_out, 0);
    chk({name, "_addr"},    bus.cc_caminho_addr_out, 0);
    chk({name, "_comp"},    bus.cc_comprimento_out, 0);
    chk({name, "_ocupado"}, bus.cc_ocupado_out, 0);
    chk({name, "_pronto"},  bus.cc_caminho_pronto_out, 0);
    chk({name, "_erro"},    bus.cc_erro_out, 0);
    chk({name, "_estado"},  bus.cc_estado_dbg_out, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    n_checks = 0;
    n_err    = 0;
    chk_en   = 1'b0;
    lido_mode = 0;
    bus.cme_construir_caminho_in = 1'b0;
    bus.top_fonte_in   = '0;
    bus.top_destino_in = '0;
    for (int i = 0; i < 64; i++) anterior[i] = '0;
    anterior[12] = 6'd9;
    anterior[9]  = 6'd3;
    anterior[3]  = 6'd0;
    anterior[1]  = 6'd2;
    anterior[2]  = 6'd1;

    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n  = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);

    // fonte == destino: one word, no memory read.
    start_path(6'd5, 6'd5, 1'b0);
    finish_path("t1", lat);
    chk("t1_latency", lat, 1);
    chk("t1_len_lit", bus.cc_comprimento_out, 1);
    lit_q = '{6'd5};
    check_got("t1", lit_q);
    repeat (5) @(negedge clk);

    // Four-node walk, lido held high.
    start_path(6'd0, 6'd12, 1'b0);
    finish_path("t2", lat);
    chk("t2_latency", lat, 7);
    chk("t2_len_lit", bus.cc_comprimento_out, 4);
    lit_q = '{6'd0, 6'd3, 6'd9, 6'd12};
    check_got("t2", lit_q);
    repeat (5) @(negedge clk);

    // Same walk, lido one cycle in three.
    lido_mode = 1;
    start_path(6'd0, 6'd12, 1'b0);
    finish_path("t3", lat);
    check_got("t3", lit_q);
    lido_mode = 0;
    repeat (5) @(negedge clk);

    // Cyclic table: error after 64 nodes, then a good start clears erro.
    start_path(6'd7, 6'd1, 1'b0);
    finish_path("t4", lat);
    chk("t4_erro_lit", bus.cc_erro_out, 1);
    chk("t4_len_lit", bus.cc_comprimento_out, 64);
    chk("t4_no_words", got_q.size(), 0);
    chk("t4_valid_seen", (lat > 0), 0);
    start_path(6'd5, 6'd5, 1'b0);
    chk("t4_erro_clear", bus.cc_erro_out, 0);
    finish_path("t4b", lat);
    lit_q = '{6'd5};
    check_got("t4b", lit_q);
    repeat (5) @(negedge clk);

    // Start held high through the walk and into ENVIAR.
    lido_mode = 2;
    start_path(6'd0, 6'd12, 1'b1);
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.cc_caminho_valido_out) break;
    end
    if (n == 50) chk("t5_wait_valido", 1, 0);
    repeat (3) @(negedge clk);
    lido_mode = 0;
    @(posedge clk); #1;
    bus.cme_construir_caminho_in = 1'b0;
    finish_path("t5", lat);
    repeat (6) @(negedge clk);
    lit_q = '{6'd0, 6'd3, 6'd9, 6'd12};
    check_got("t5", lit_q);

    // Reset after two of four words, then a clean walk.
    start_path(6'd0, 6'd12, 1'b0);
    for (n = 0; n < 50; n++) begin
      @(negedge clk); #1;
      if (got_q.size() >= 2) break;
    end
    if (n == 50) chk("t6_wait_words", 1, 0);
    @(posedge clk); #2;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_idle_outputs("t6_reset");
    exp_q.delete();
    exp_rd_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    start_path(6'd0, 6'd12, 1'b0);
    finish_path("t6", lat);
    chk("t6_len_lit", bus.cc_comprimento_out, 4);
    check_got("t6", lit_q);
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/construtor_caminho.md
Name: construtor_caminho

Overview:
- Reader side of the predecessor ("anterior") memory.
- The pathfinding datapath writes one predecessor per established node. When the state-machine controller asserts construir_caminho, this block walks that memory from destino back to fonte.
- It pushes every node onto an internal LIFO, then streams the path to the host in fonte→destino order over a valid/lido handshake.
- It produces the caminho_pronto and lido-side signals the controller consumes.

Parameters:
- ADDR_WIDTH, 6: node address width.
- PROFUNDIDADE, 2**ADDR_WIDTH: LIFO depth; also the maximum path length in nodes.
- CONT_WIDTH, ADDR_WIDTH+1: width of the length counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cme_construir_caminho_in  in  1  start request from the controller; level-sampled in OCIOSO only.
- top_fonte_in  in  ADDR_WIDTH  registered source node.
- top_destino_in  in  ADDR_WIDTH  registered destination node.
- cc_anterior_rd_en_out  out  1  predecessor memory read enable.
- cc_anterior_rd_addr_out  out  ADDR_WIDTH  predecessor memory read address.
- gma_anterior_rd_data_in  in  ADDR_WIDTH  read data, valid exactly 1 cycle after rd_en.
- cc_caminho_valido_out  out  1  path word valid to the host.
- cc_caminho_addr_out  out  ADDR_WIDTH  path node; fonte first.
- host_lido_in  in  1  host accepts the word this cycle.
- cc_comprimento_out  out  CONT_WIDTH  number of nodes in the path; stable from ENVIAR entry until the next start.
- cc_ocupado_out  out  1  high in every state except OCIOSO.
- cc_caminho_pronto_out  out  1  one-cycle pulse after the last word is accepted.
- cc_erro_out  out  1  sticky; set on overflow, cleared on the next accepted start.

Behaviour:
- Reset: FSM in OCIOSO; LIFO empty; counters 0; all outputs 0.
- FSM states: OCIOSO, LER, ESPERA, ENVIAR, FIM, ERRO.
- OCIOSO, start accepted (cme_construir_caminho_in=1):
  - latch fonte/destino;
  - push destino; comprimento=1; cur=destino; clear erro;
  - if destino==fonte → ENVIAR, else → LER.
- LER: rd_en=1, rd_addr=cur for exactly one cycle → ESPERA.
- ESPERA: sample gma_anterior_rd_data_in as d, push d, comprimento+1, then:
  - d==fonte → ENVIAR;
  - else comprimento+1==PROFUNDIDADE → ERRO (loop or corrupt table);
  - else cur=d → LER.
- Walk cost: 2 cycles per hop. A path of N nodes reaches ENVIAR 2(N-1) cycles after start acceptance.
- ENVIAR:
  - valido = LIFO not empty; addr = LIFO top (combinational from the storage array).
  - valido & lido → pop. lido while valido=0 is ignored.
  - Data and valido hold stable while lido=0.
  - Popping the last entry → FIM.
- FIM: caminho_pronto=1 for one cycle → OCIOSO.
- ERRO: erro=1 (sticky); LIFO cleared; no words are streamed → OCIOSO.
- Start requests outside OCIOSO are ignored; no queueing.
- The fonte/destino inputs are only sampled at start; later changes have no effect.
- Reset mid-operation: immediate return to reset state; a partially streamed path is discarded.
- LIFO push and pop never coincide (separate states), so no simultaneous push/pop handling is required.
- Push on full is impossible by construction (ERRO fires first).

Decomposition:
- Shared package, included by this block and the controller: FSM state localparams (3-bit encoding).
- Sub-module pilha_caminho: parameterised LIFO (ADDR_WIDTH data, PROFUNDIDADE entries).
  - Inputs: push, pop, clear, din.
  - Outputs: top, vazio, cheio.
  - Register-array storage with an async-reset pointer.

Test Plan:
- fonte=5, destino=5, start → valido next cycle with addr=5; lido → caminho_pronto pulse; comprimento=1; no memory read issued.
- Memory anterior[12]=9, [9]=3, [3]=0; fonte=0, destino=12 → reads at 12, 9, 3; then stream 0,3,9,12 with lido held high; comprimento=4; pronto 1 cycle after the last accept.
- Same path with lido toggling 1-of-3 cycles → addr/valido hold steady while lido=0; order still 0,3,9,12; no duplicates.
- Cyclic table anterior[1]=2, [2]=1; fonte=7, destino=1 → erro=1 after the comprimento limit (64 nodes); valido never asserts; ocupado drops; a following valid start clears erro.
- Start pulse held high during ENVIAR → ignored; exactly one path is streamed.
- rst_n low mid-ENVIAR (after 2 of 4 words) → all outputs 0 asynchronously; a new start after release runs a clean walk.
